alien_hit_detector: RTL and testbench
=====================================

Name: alien_hit_detector

Overview:
- Target-side responder for the player shot. On each shot position update it takes the bullet coordinates and scans the alien grid one alien per cycle.
- On a hit it kills the first matching alien and returns a one-cycle collision result, which the shot controller uses to end the shot.
- It owns the alien alive mask, a kill counter and the all-dead flag. It sits between the shot datapath and the alien renderer/wave logic.

Parameters:
- ROWS, 3, alien grid rows
- COLS, 8, alien grid columns
- ALIEN_W, 8, alien hit box width in pixels
- ALIEN_H, 6, alien hit box height in pixels
- X_PITCH, 14, column-to-column x spacing
- Y_PITCH, 10, row-to-row y spacing
- IDX_W, 5, width of the alien index; must satisfy 2^IDX_W >= ROWS*COLS

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- checkReq  in  1  one-cycle request: check bulletX/bulletY against the grid
- bulletX  in  8  bullet x, sampled with checkReq
- bulletY  in  7  bullet y, sampled with checkReq
- gridX  in  8  grid origin x (top-left of alien 0), sampled with checkReq
- gridY  in  7  grid origin y, sampled with checkReq
- newWave  in  1  restore all aliens alive
- busy  out  1  high while a check is in progress
- doneValid  out  1  one-cycle pulse when a check result is available
- collidedWithAlien  out  1  result flag, valid only while doneValid is high
- hitIndex  out  IDX_W  index of the killed alien, valid while doneValid and collidedWithAlien are high
- aliveMask  out  ROWS*COLS  bit i = alien i alive; index = row*COLS + col
- allDead  out  1  high when aliveMask == 0
- killCount  out  8  total kills, saturates at 255

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM returns to IDLE, aborting any scan.
  - aliveMask = all ones; killCount = 0.
  - busy, doneValid, collidedWithAlien = 0; hitIndex = 0; no doneValid is emitted for the aborted check.
- States:
  - IDLE: busy=0. checkReq latches bullet and grid coordinates, sets idx=0 and goes to SCAN.
  - SCAN: busy=1. Tests alien idx each cycle.
    - Hit: go to REPORT with hit=1.
    - Miss with idx==ROWS*COLS-1: go to REPORT with hit=0.
    - Otherwise: idx+1.
  - REPORT: busy=1. doneValid=1 for exactly this cycle; collidedWithAlien=hit. On hit, clear aliveMask[idx] and increment killCount (saturating); both visible the next cycle. Go to IDLE.
- Timing: checkReq accepted at cycle 0 means idx k is tested at cycle k+1.
  - Hit at idx k: doneValid at cycle k+2.
  - Full miss: doneValid at cycle ROWS*COLS+1 (25 with defaults).
- checkReq while busy is ignored and not queued.
- Hit rule for alien (r,c), with all arithmetic at 9 bits (no wrap):
  - ax = gridX + c*X_PITCH; ay = gridY + r*Y_PITCH.
  - Hit iff aliveMask[idx] && ax <= bx < ax+ALIEN_W && ay <= by < ay+ALIEN_H.
  - Boxes that extend past 255/127 never alias to small coordinates.
- At most one alien killed per check, the lowest index that matches (early exit).
- Grid motion during a scan has no effect; only the latched origin is used.
- newWave:
  - In IDLE: aliveMask = all ones next cycle; killCount is kept.
  - In SCAN or REPORT: the scan aborts, mask is restored, no doneValid, FSM goes to IDLE.
  - newWave together with checkReq in IDLE: newWave wins and the request is dropped.
- allDead is combinational from the registered aliveMask.

Decomposition:
- Shared package (shots_pkg): grid defaults (ROWS, COLS, ALIEN_W/H, pitches), IDX_W, the FSM state encoding (IDLE/SCAN/REPORT), and the bullet coordinate widths (8/7) shared with the shot datapath.
- One natural sub-module, alien_box_compare: combinational; takes latched origin, r, c, bx, by and returns the in-box flag with 9-bit arithmetic. The FSM derives r and c from idx using incrementing row/col counters, not division.

Test Plan:
- Reset, grid (10,10), checkReq with bullet (12,12): doneValid at cycle 2, collided=1, hitIndex=0, aliveMask[0]=0 next cycle, killCount=1.
- Bullet (24,20), same grid: hit alien 9 (row 1, col 1), doneValid at cycle 11. Repeat the identical request: collided=0, doneValid at cycle 25, killCount unchanged.
- Edge exclusion: bullet (18,12) and (12,16) each give a miss. Bullet (17,15) hits alien 0.
- Overflow: gridX=250, bullet (8,10) gives a miss (col 1 at ax=264 must not alias). Second checkReq sent at cycle 3 is ignored, with busy=1 throughout.
- Kill all 24 aliens by targeted checks: allDead=1. newWave then gives aliveMask=24'hFFFFFF and allDead=0; killCount=24.
- newWave at cycle 5 of a scan: no doneValid, busy=0 next cycle, mask all ones. Also drive reset=0 mid-scan: same abort, plus killCount=0.

Source files
------------

// File: rtl/shots_pkg.sv
// rtl/shots_pkg.sv - shared grid geometry, coordinate widths and hit-detector FSM encoding
package shots_pkg;

  // Default alien grid geometry
  localparam int GRID_ROWS    = 3;
  localparam int GRID_COLS    = 8;
  localparam int GRID_ALIEN_W = 8;
  localparam int GRID_ALIEN_H = 6;
  localparam int GRID_X_PITCH = 14;
  localparam int GRID_Y_PITCH = 10;
  localparam int GRID_IDX_W   = 5;

  // Bullet / grid coordinate widths shared with the shot datapath
  localparam int BX_W = 8;
  localparam int BY_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } hit_state_t;

endpackage

// File: rtl/alien_box_compare.sv
// rtl/alien_box_compare.sv - combinational test of a bullet against one alien hit box
//
// Ports:
//   origin_x/origin_y : latched grid origin (top-left of alien 0)
//   row/col           : grid position of the alien under test
//   bx/by             : latched bullet coordinates
//   in_box            : bullet lies inside the alien box
//
// All arithmetic is 9 bits wide so boxes pushed past the screen edge keep
// their true position instead of wrapping onto small coordinates.
module alien_box_compare
  import shots_pkg::*;
#(
  parameter int X_PITCH = GRID_X_PITCH,
  parameter int Y_PITCH = GRID_Y_PITCH,
  parameter int ALIEN_W = GRID_ALIEN_W,
  parameter int ALIEN_H = GRID_ALIEN_H,
  parameter int ROW_W   = 2,
  parameter int COL_W   = 3
) (
  input  logic [BX_W-1:0]  origin_x,
  input  logic [BY_W-1:0]  origin_y,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [BX_W-1:0]  bx,
  input  logic [BY_W-1:0]  by,
  output logic             in_box
);

  logic [8:0] ax;
  logic [8:0] ay;
  logic [8:0] bx9;
  logic [8:0] by9;

  assign ax  = 9'(origin_x) + 9'(col) * 9'(X_PITCH);
  assign ay  = 9'(origin_y) + 9'(row) * 9'(Y_PITCH);
  assign bx9 = 9'(bx);
  assign by9 = 9'(by);

  assign in_box = (bx9 >= ax) && (bx9 < ax + 9'(ALIEN_W)) &&
                  (by9 >= ay) && (by9 < ay + 9'(ALIEN_H));

endmodule

// File: rtl/alien_hit_detector.sv
// rtl/alien_hit_detector.sv - scans the alien grid for a bullet hit and owns the alive mask
//
// Ports:
//   clk, reset         : clock, synchronous active-low reset
//   checkReq           : start a scan with bulletX/bulletY/gridX/gridY (ignored while busy)
//   newWave            : restore all aliens; aborts a scan in progress
//   busy               : scan or report in progress
//   doneValid          : one-cycle result strobe
//   collidedWithAlien  : result flag (with doneValid)
//   hitIndex           : killed alien index (with doneValid && collidedWithAlien)
//   aliveMask          : bit row*COLS+col set while that alien lives
//   allDead            : aliveMask is empty
//   killCount          : saturating kill total
module alien_hit_detector
  import shots_pkg::*;
#(
  parameter int ROWS    = GRID_ROWS,
  parameter int COLS    = GRID_COLS,
  parameter int ALIEN_W = GRID_ALIEN_W,
  parameter int ALIEN_H = GRID_ALIEN_H,
  parameter int X_PITCH = GRID_X_PITCH,
  parameter int Y_PITCH = GRID_Y_PITCH,
  parameter int IDX_W   = GRID_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 checkReq,
  input  logic [BX_W-1:0]      bulletX,
  input  logic [BY_W-1:0]      bulletY,
  input  logic [BX_W-1:0]      gridX,
  input  logic [BY_W-1:0]      gridY,
  input  logic                 newWave,
  output logic                 busy,
  output logic                 doneValid,
  output logic                 collidedWithAlien,
  output logic [IDX_W-1:0]     hitIndex,
  output logic [ROWS*COLS-1:0] aliveMask,
  output logic                 allDead,
  output logic [7:0]           killCount
);

  localparam int N     = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  hit_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [BX_W-1:0]  bx_q, gx_q;
  logic [BY_W-1:0]  by_q, gy_q;
  logic             hit_q;

  logic in_box;
  logic alien_hit;
  logic idx_last;
  logic accept;
  logic advance;
  logic kill;

  alien_box_compare #(
    .X_PITCH (X_PITCH),
    .Y_PITCH (Y_PITCH),
    .ALIEN_W (ALIEN_W),
    .ALIEN_H (ALIEN_H),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) u_box (
    .origin_x (gx_q),
    .origin_y (gy_q),
    .row      (row_q),
    .col      (col_q),
    .bx       (bx_q),
    .by       (by_q),
    .in_box   (in_box)
  );

  assign alien_hit = in_box && aliveMask[idx_q];
  assign idx_last  = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    advance           = 1'b0;
    busy              = 1'b0;
    doneValid         = 1'b0;
    collidedWithAlien = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // newWave takes priority; a simultaneous request is dropped
        if (!newWave && checkReq) begin
          accept  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (newWave)                    state_d = ST_IDLE;
        else if (alien_hit || idx_last) state_d = ST_REPORT;
        else                            advance = 1'b1;
      end
      ST_REPORT: begin
        busy    = 1'b1;
        state_d = ST_IDLE;
        // an abort in the report cycle suppresses the result and the kill
        if (!newWave) begin
          doneValid         = 1'b1;
          collidedWithAlien = hit_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign kill     = doneValid && hit_q;
  assign hitIndex = idx_q;
  assign allDead  = (aliveMask == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      hit_q     <= 1'b0;
      aliveMask <= {N{1'b1}};
      killCount <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bx_q  <= bulletX;
        by_q  <= bulletY;
        gx_q  <= gridX;
        gy_q  <= gridY;
        idx_q <= '0;
        row_q <= '0;
        col_q <= '0;
      end else if (advance) begin
        idx_q <= idx_q + 1'b1;
        // row/col track idx so the box position needs no division
        if (col_q == COL_W'(COLS - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      // the last SCAN cycle leaves its verdict here for REPORT
      if (state_q == ST_SCAN) hit_q <= alien_hit;
      if (newWave)   aliveMask        <= {N{1'b1}};
      else if (kill) aliveMask[idx_q] <= 1'b0;
      if (kill && killCount != 8'hFF) killCount <= killCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_alien_hit_detector.sv
// tb/tb_alien_hit_detector.sv - scoreboard bench for alien_hit_detector
module tb_alien_hit_detector;
  import shots_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        checkReq = 1'b0;
  logic [7:0]  bulletX = '0;
  logic [6:0]  bulletY = '0;
  logic [7:0]  gridX = '0;
  logic [6:0]  gridY = '0;
  logic        newWave = 1'b0;
  logic        busy, doneValid, collidedWithAlien;
  logic [4:0]  hitIndex;
  logic [23:0] aliveMask;
  logic        allDead;
  logic [7:0]  killCount;

  alien_hit_detector dut (
    .clk               (clk),
    .reset             (reset),
    .checkReq          (checkReq),
    .bulletX           (bulletX),
    .bulletY           (bulletY),
    .gridX             (gridX),
    .gridY             (gridY),
    .newWave           (newWave),
    .busy              (busy),
    .doneValid         (doneValid),
    .collidedWithAlien (collidedWithAlien),
    .hitIndex          (hitIndex),
    .aliveMask         (aliveMask),
    .allDead           (allDead),
    .killCount         (killCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       hit;
    logic [4:0] idx;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && doneValid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: doneValid with nothing expected (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("collided", 32'(collidedWithAlien), 32'(e.hit));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        if (e.hit) check("hit_index", 32'(hitIndex), 32'(e.idx));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      step();
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue a request and register the hand-computed result and its cycle
  task automatic do_check(input logic [7:0] bx, input logic [6:0] by,
                          input logic [7:0] gx, input logic [6:0] gy,
                          input logic hit, input logic [4:0] idx);
    exp_t e;
    bulletX  = bx;
    bulletY  = by;
    gridX    = gx;
    gridY    = gy;
    checkReq = 1'b1;
    e.hit = hit;
    e.idx = idx;
    e.cyc = cyc + (hit ? int'(idx) + 2 : 25);
    exp_q.push_back(e);
    step();
    checkReq = 1'b0;
    wait_idle();
  endtask

  task automatic start_unchecked(input logic [7:0] bx, input logic [6:0] by);
    bulletX  = bx;
    bulletY  = by;
    gridX    = 8'd10;
    gridY    = 7'd10;
    checkReq = 1'b1;
    step();
    checkReq = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(doneValid), 32'd0);
    check("rst_coll", 32'(collidedWithAlien), 32'd0);
    check("rst_hitidx", 32'(hitIndex), 32'd0);
    check("rst_mask", 32'(aliveMask), 32'hFFFFFF);
    check("rst_kills", 32'(killCount), 32'd0);
    check("rst_alldead", 32'(allDead), 32'd0);
    reset = 1'b1;
    step();

    // Basic hits and a full miss on a dead target
    do_check(8'd12, 7'd12, 8'd10, 7'd10, 1'b1, 5'd0);
    check("mask_after_0", 32'(aliveMask), 32'hFFFFFE);
    check("kills_1", 32'(killCount), 32'd1);
    do_check(8'd24, 7'd20, 8'd10, 7'd10, 1'b1, 5'd9);
    check("mask_after_9", 32'(aliveMask), 32'hFFFDFE);
    do_check(8'd24, 7'd20, 8'd10, 7'd10, 1'b0, 5'd0);
    check("kills_2", 32'(killCount), 32'd2);

    // newWave and checkReq together in IDLE: request dropped, mask restored
    bulletX = 8'd12; bulletY = 7'd12; gridX = 8'd10; gridY = 7'd10;
    checkReq = 1'b1;
    newWave  = 1'b1;
    step();
    checkReq = 1'b0;
    newWave  = 1'b0;
    check("nw_drop_busy", 32'(busy), 32'd0);
    check("nw_mask", 32'(aliveMask), 32'hFFFFFF);
    check("nw_kills_kept", 32'(killCount), 32'd2);

    // Box edges are exclusive on the far side
    do_check(8'd18, 7'd12, 8'd10, 7'd10, 1'b0, 5'd0);
    do_check(8'd12, 7'd16, 8'd10, 7'd10, 1'b0, 5'd0);
    do_check(8'd17, 7'd15, 8'd10, 7'd10, 1'b1, 5'd0);
    check("kills_3", 32'(killCount), 32'd3);

    // Column 1 at x=264 must not alias onto x=8; a second request mid-scan is ignored
    begin
      exp_t e;
      bulletX = 8'd8; bulletY = 7'd10; gridX = 8'd250; gridY = 7'd10;
      checkReq = 1'b1;
      e.hit = 1'b0; e.idx = '0; e.cyc = cyc + 25;
      exp_q.push_back(e);
      step();
      for (int t = 1; t <= 25; t++) begin
        check("ovf_busy", 32'(busy), 32'd1);
        checkReq = (t == 3);
        step();
      end
      checkReq = 1'b0;
      check("ovf_idle", 32'(busy), 32'd0);
      step();
      step();
      check("ovf_no_requeue", 32'(busy), 32'd0);
      check("ovf_kills", 32'(killCount), 32'd3);
    end

    // Fresh start, then kill the whole grid one target at a time
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        do_check(8'(10 + c * 14 + 1), 7'(10 + r * 10 + 1), 8'd10, 7'd10,
                 1'b1, 5'(r * 8 + c));
      end
    end
    check("all_mask", 32'(aliveMask), 32'h000000);
    check("all_dead", 32'(allDead), 32'd1);
    check("all_kills", 32'(killCount), 32'd24);
    newWave = 1'b1;
    step();
    newWave = 1'b0;
    check("wave_mask", 32'(aliveMask), 32'hFFFFFF);
    check("wave_alldead", 32'(allDead), 32'd0);
    check("wave_kills", 32'(killCount), 32'd24);

    // Abort by newWave at scan cycle 5
    do_check(8'd12, 7'd12, 8'd10, 7'd10, 1'b1, 5'd0);
    check("pre_abort_mask", 32'(aliveMask), 32'hFFFFFE);
    start_unchecked(8'd0, 7'd0);
    repeat (4) step();
    check("abort_busy_before", 32'(busy), 32'd1);
    newWave = 1'b1;
    step();
    newWave = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mask", 32'(aliveMask), 32'hFFFFFF);
    check("abort_kills", 32'(killCount), 32'd25);
    repeat (30) step();

    // Abort by reset at scan cycle 5
    start_unchecked(8'd0, 7'd0);
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_abort_busy", 32'(busy), 32'd0);
    check("rst_abort_mask", 32'(aliveMask), 32'hFFFFFF);
    check("rst_abort_kills", 32'(killCount), 32'd0);
    repeat (30) step();

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
